// File: rtl/cu_read_command_responder.sv
// Command FIFO plus issue/retire tracker between a CU and a downstream engine.
// Commands are queued, issued one at a time through a registered output stage,
// tracked by tag in a bitmap until their completion comes back, and the
// completion is forwarded to the CU one cycle later.
module cu_read_command_responder #(
    parameter int FIFO_DEPTH      = 16,
    parameter int PAYLOAD_W       = 128,
    parameter int TAG_W           = 8,
    parameter int MAX_OUTSTANDING = 16,
    parameter int ALMOST_FULL_TH  = 12,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1,
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                 clock,
    input  logic                 rst_in,
    input  logic                 enabled_in,
    input  logic                 command_in_valid,
    input  logic [PAYLOAD_W-1:0] command_in_payload,
    output logic                 status_full,
    output logic                 status_almost_full,
    output logic                 status_empty,
    output logic [CNT_W-1:0]     status_count,
    output logic                 command_out_valid,
    output logic [PAYLOAD_W-1:0] command_out_payload,
    input  logic                 command_out_ready,
    input  logic                 response_in_valid,
    input  logic [TAG_W-1:0]     response_in_tag,
    input  logic [1:0]           response_in_code,
    output logic                 response_out_valid,
    output logic [TAG_W-1:0]     response_out_tag,
    output logic [1:0]           response_out_code,
    output logic [OUT_W-1:0]     outstanding_count,
    output logic                 drain_done,
    output logic [1:0]           error_sticky
);

    localparam int NTAGS = 1 << TAG_W;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                 state_reg, state_next;
    logic [PAYLOAD_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic [OUT_W-1:0]       outst_reg, outst_next;
    logic [NTAGS-1:0]       bitmap_reg, bitmap_next;
    logic                   out_valid_reg;
    logic [PAYLOAD_W-1:0]   out_payload_reg;
    logic                   resp_valid_reg;
    logic [TAG_W-1:0]       resp_tag_reg;
    logic [1:0]             resp_code_reg;
    logic [1:0]             err_reg;

    logic                   full, push, overflow, fire, retire, unknown;
    logic [PTR_W-1:0]       head_idx;
    logic [PAYLOAD_W-1:0]   head_payload;
    logic [TAG_W-1:0]       head_tag, out_tag;
    logic                   have_head, tag_busy, issue_state, slot_free, load;

    assign full        = (count_reg == CNT_W'(FIFO_DEPTH));
    assign push        = command_in_valid && !full;
    assign overflow    = command_in_valid && full;
    assign fire        = out_valid_reg && command_out_ready;
    assign retire      = response_in_valid && bitmap_reg[response_in_tag];
    assign unknown     = response_in_valid && !bitmap_reg[response_in_tag];
    assign out_tag     = out_payload_reg[TAG_W-1:0];

    // The entry behind the current head becomes the head when the current one transfers.
    assign head_idx     = fire ? (rd_ptr_reg + PTR_W'(1)) : rd_ptr_reg;
    assign head_payload = mem[head_idx];
    assign head_tag     = head_payload[TAG_W-1:0];
    assign have_head    = fire ? (count_reg > CNT_W'(1)) : (count_reg != '0);

    // A tag issuing this edge is not yet in the bitmap, so compare it directly too.
    assign tag_busy    = bitmap_reg[head_tag] || (fire && (out_tag == head_tag));
    assign issue_state = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign slot_free   = !out_valid_reg || fire;
    assign outst_next  = outst_reg + OUT_W'(fire) - OUT_W'(retire);
    assign load        = issue_state && slot_free && have_head && !tag_busy &&
                         (outst_next < OUT_W'(MAX_OUTSTANDING));
    assign count_next  = count_reg + CNT_W'(push) - CNT_W'(fire);

    // Per-tag outstanding bit: set on issue, cleared on matching completion.
    generate
        for (genvar gi = 0; gi < NTAGS; gi++) begin : g_bitmap
            assign bitmap_next[gi] = (fire && (out_tag == TAG_W'(gi))) ? 1'b1 :
                                     (retire && (response_in_tag == TAG_W'(gi))) ? 1'b0 :
                                     bitmap_reg[gi];
        end
    endgenerate

    // FIFO storage write port (no reset; validity is carried by the pointers).
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= command_in_payload;
        end
    end

    // Pointers, occupancy, tracking state and error flags.
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            outst_reg  <= '0;
            bitmap_reg <= '0;
            err_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (fire) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg  <= count_next;
            outst_reg  <= outst_next;
            bitmap_reg <= bitmap_next;
            err_reg    <= err_reg | {unknown, overflow};
        end
    end

    // Registered issue stage: holds the head until it transfers, reloads back-to-back.
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) begin
            out_valid_reg   <= 1'b0;
            out_payload_reg <= '0;
        end else if (load) begin
            out_valid_reg   <= 1'b1;
            out_payload_reg <= head_payload;
        end else if (fire) begin
            out_valid_reg   <= 1'b0;
        end
    end

    // Completion forwarding with one cycle of latency, one-cycle pulse.
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) begin
            resp_valid_reg <= 1'b0;
            resp_tag_reg   <= '0;
            resp_code_reg  <= '0;
        end else begin
            resp_valid_reg <= retire;
            if (retire) begin
                resp_tag_reg  <= response_in_tag;
                resp_code_reg <= response_in_code;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (enabled_in) state_next = ST_RUN;
            ST_RUN:   if (!enabled_in) state_next = ST_DRAIN;
            ST_DRAIN: if ((count_reg == '0) && (outst_reg == '0)) state_next = ST_DONE;
            ST_DONE:  if (enabled_in) state_next = ST_RUN;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign status_full         = full;
    assign status_almost_full  = (count_reg >= CNT_W'(ALMOST_FULL_TH));
    assign status_empty        = (count_reg == '0);
    assign status_count        = count_reg;
    assign command_out_valid   = out_valid_reg;
    assign command_out_payload = out_payload_reg;
    assign response_out_valid  = resp_valid_reg;
    assign response_out_tag    = resp_tag_reg;
    assign response_out_code   = resp_code_reg;
    assign outstanding_count   = outst_reg;
    assign drain_done          = (state_reg == ST_DONE);
    assign error_sticky        = err_reg;

endmodule

// File: tb/tb_cu_read_command_responder.sv
// Directed bench: a vector table for the basic issue/retire flow, then
// hand-written sequences for overflow, outstanding cap, tag collision,
// drain and asynchronous reset.
module tb_cu_read_command_responder;

    logic         clock = 1'b0;
    logic         rst_in;
    logic         enabled_in;
    logic         command_in_valid;
    logic [127:0] command_in_payload;
    logic         status_full, status_almost_full, status_empty;
    logic [4:0]   status_count;
    logic         command_out_valid;
    logic [127:0] command_out_payload;
    logic         command_out_ready;
    logic         response_in_valid;
    logic [7:0]   response_in_tag;
    logic [1:0]   response_in_code;
    logic         response_out_valid;
    logic [7:0]   response_out_tag;
    logic [1:0]   response_out_code;
    logic [4:0]   outstanding_count;
    logic         drain_done;
    logic [1:0]   error_sticky;

    int checks = 0;
    int errors = 0;

    cu_read_command_responder dut (
        .clock(clock), .rst_in(rst_in), .enabled_in(enabled_in),
        .command_in_valid(command_in_valid), .command_in_payload(command_in_payload),
        .status_full(status_full), .status_almost_full(status_almost_full),
        .status_empty(status_empty), .status_count(status_count),
        .command_out_valid(command_out_valid), .command_out_payload(command_out_payload),
        .command_out_ready(command_out_ready),
        .response_in_valid(response_in_valid), .response_in_tag(response_in_tag),
        .response_in_code(response_in_code),
        .response_out_valid(response_out_valid), .response_out_tag(response_out_tag),
        .response_out_code(response_out_code),
        .outstanding_count(outstanding_count), .drain_done(drain_done),
        .error_sticky(error_sticky)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       en;
        logic       cv;
        logic [7:0] ctag;
        logic       rdy;
        logic       rv;
        logic [7:0] rtag;
        logic [1:0] rcode;
        logic       e_ov;
        logic [7:0] e_otag;
        logic [4:0] e_cnt;
        logic [4:0] e_outst;
        logic       e_rv;
        logic [7:0] e_rtag;
        logic [1:0] e_rcode;
        logic [1:0] e_err;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [127:0] pl(input logic [7:0] t);
        return {16{t}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic cv, input logic [7:0] ctag, input logic rv,
                         input logic [7:0] rtag, input logic [1:0] rcode);
        command_in_valid   = cv;
        command_in_payload = pl(ctag);
        response_in_valid  = rv;
        response_in_tag    = rtag;
        response_in_code   = rcode;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        enabled_in = 1'b0;
        command_out_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 2'd0);
        step();
        step();
        rst_in = 1'b0;
    endtask

    task automatic wait_outst(input string name, input logic [4:0] target, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (outstanding_count == target) break;
            step();
        end
        chk(name, outstanding_count, target);
    endtask

    initial begin
        int issued;
        logic [4:0] exp_cnt;

        vecs[0]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,2'd0, 1'b0,8'h00,5'd0,5'd0,1'b0,8'h00,2'd0,2'b00};
        vecs[1]  = '{1'b1,1'b1,8'h05,1'b1,1'b0,8'h00,2'd0, 1'b0,8'h00,5'd1,5'd0,1'b0,8'h00,2'd0,2'b00};
        vecs[2]  = '{1'b1,1'b0,8'h00,1'b1,1'b0,8'h00,2'd0, 1'b1,8'h05,5'd1,5'd0,1'b0,8'h00,2'd0,2'b00};
        vecs[3]  = '{1'b1,1'b0,8'h00,1'b1,1'b0,8'h00,2'd0, 1'b0,8'h00,5'd0,5'd1,1'b0,8'h00,2'd0,2'b00};
        vecs[4]  = '{1'b1,1'b0,8'h00,1'b0,1'b1,8'h05,2'd0, 1'b0,8'h00,5'd0,5'd0,1'b1,8'h05,2'd0,2'b00};
        vecs[5]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,2'd0, 1'b0,8'h00,5'd0,5'd0,1'b0,8'h00,2'd0,2'b00};
        vecs[6]  = '{1'b1,1'b1,8'h11,1'b0,1'b0,8'h00,2'd0, 1'b0,8'h00,5'd1,5'd0,1'b0,8'h00,2'd0,2'b00};
        vecs[7]  = '{1'b1,1'b1,8'h22,1'b1,1'b0,8'h00,2'd0, 1'b1,8'h11,5'd2,5'd0,1'b0,8'h00,2'd0,2'b00};
        vecs[8]  = '{1'b1,1'b0,8'h00,1'b1,1'b0,8'h00,2'd0, 1'b1,8'h22,5'd1,5'd1,1'b0,8'h00,2'd0,2'b00};
        vecs[9]  = '{1'b1,1'b0,8'h00,1'b1,1'b1,8'h11,2'd2, 1'b0,8'h00,5'd0,5'd1,1'b1,8'h11,2'd2,2'b00};
        vecs[10] = '{1'b1,1'b0,8'h00,1'b0,1'b1,8'h22,2'd3, 1'b0,8'h00,5'd0,5'd0,1'b1,8'h22,2'd3,2'b00};
        vecs[11] = '{1'b1,1'b0,8'h00,1'b0,1'b1,8'h7F,2'd0, 1'b0,8'h00,5'd0,5'd0,1'b0,8'h00,2'd0,2'b10};

        // Reset state
        do_reset();
        chk("rst_empty", status_empty, 1'b1);
        chk("rst_count", status_count, 5'd0);
        chk("rst_ov", command_out_valid, 1'b0);
        chk("rst_drain_done", drain_done, 1'b0);
        chk("rst_err", error_sticky, 2'b00);

        // Basic issue/retire flow, unknown tag at the end
        for (int i = 0; i < 12; i++) begin
            enabled_in = vecs[i].en;
            command_out_ready = vecs[i].rdy;
            drive(vecs[i].cv, vecs[i].ctag, vecs[i].rv, vecs[i].rtag, vecs[i].rcode);
            step();
            $display("vec %0d ov=%0b cnt=%0d outst=%0d rv=%0b rtag=%0h err=%0b", i,
                     command_out_valid, status_count, outstanding_count,
                     response_out_valid, response_out_tag, error_sticky);
            chk("vec_ov", command_out_valid, vecs[i].e_ov);
            if (vecs[i].e_ov) chk("vec_payload", command_out_payload, pl(vecs[i].e_otag));
            chk("vec_count", status_count, vecs[i].e_cnt);
            chk("vec_empty", status_empty, vecs[i].e_cnt == 5'd0);
            chk("vec_outst", outstanding_count, vecs[i].e_outst);
            chk("vec_rv", response_out_valid, vecs[i].e_rv);
            if (vecs[i].e_rv) begin
                chk("vec_rtag", response_out_tag, vecs[i].e_rtag);
                chk("vec_rcode", response_out_code, vecs[i].e_rcode);
            end
            chk("vec_err", error_sticky, vecs[i].e_err);
        end

        // Overflow: 17 pushes with no issuing
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 8'(i), 1'b0, 8'h00, 2'd0);
            step();
            exp_cnt = (i > 16) ? 5'd16 : 5'(i);
            $display("push %0d cnt=%0d af=%0b full=%0b err=%0b", i, status_count,
                     status_almost_full, status_full, error_sticky);
            chk("ovf_count", status_count, exp_cnt);
            chk("ovf_af", status_almost_full, exp_cnt >= 5'd12);
            chk("ovf_full", status_full, i >= 16);
            chk("ovf_err", error_sticky, (i == 17) ? 2'b01 : 2'b00);
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 2'd0);
        chk("ovf_no_issue_idle", command_out_valid, 1'b0);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("ovf_rst_err", error_sticky, 2'b00);
        chk("ovf_rst_empty", status_empty, 1'b1);
        chk("ovf_rst_full", status_full, 1'b0);

        // Outstanding cap: 20 distinct tags, no responses
        do_reset();
        enabled_in = 1'b1;
        command_out_ready = 1'b1;
        issued = 0;
        for (int i = 0; i < 50; i++) begin
            drive(i < 20, 8'h20 + 8'(i), 1'b0, 8'h00, 2'd0);
            if (command_out_valid) issued++;
            step();
        end
        $display("cap issued=%0d outst=%0d cnt=%0d", issued, outstanding_count, status_count);
        chk("cap_issued", issued, 16);
        chk("cap_outst", outstanding_count, 5'd16);
        chk("cap_ov", command_out_valid, 1'b0);
        chk("cap_count", status_count, 5'd4);
        command_out_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 8'h20, 2'd1);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 2'd0);
        chk("cap_resp", response_out_valid, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (command_out_valid) break;
            step();
        end
        $display("cap release ov=%0b", command_out_valid);
        chk("cap_release_ov", command_out_valid, 1'b1);
        chk("cap_release_tag", command_out_payload, pl(8'h30));
        command_out_ready = 1'b1;
        step();
        chk("cap_reissue_outst", outstanding_count, 5'd16);

        // Tag collision: second 0x03 waits for the first to retire
        do_reset();
        enabled_in = 1'b1;
        command_out_ready = 1'b1;
        drive(1'b1, 8'h03, 1'b0, 8'h00, 2'd0);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 2'd0);
        wait_outst("col_first_issue", 5'd1, 10);
        drive(1'b1, 8'h03, 1'b0, 8'h00, 2'd0);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 2'd0);
        for (int k = 0; k < 5; k++) step();
        $display("col blocked ov=%0b cnt=%0d", command_out_valid, status_count);
        chk("col_blocked_ov", command_out_valid, 1'b0);
        chk("col_blocked_cnt", status_count, 5'd1);
        drive(1'b0, 8'h00, 1'b1, 8'h03, 2'd2);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 2'd0);
        chk("col_retire_ov", command_out_valid, 1'b0);
        chk("col_retire_rv", response_out_valid, 1'b1);
        chk("col_retire_code", response_out_code, 2'd2);
        chk("col_retire_outst", outstanding_count, 5'd0);
        step();
        chk("col_reload_ov", command_out_valid, 1'b1);
        chk("col_reload_tag", command_out_payload, pl(8'h03));
        chk("col_rv_pulse", response_out_valid, 1'b0);
        step();
        chk("col_reissue_outst", outstanding_count, 5'd1);

        // Drain: 1 outstanding, 2 queued, then disable
        do_reset();
        enabled_in = 1'b1;
        command_out_ready = 1'b1;
        drive(1'b1, 8'h41, 1'b0, 8'h00, 2'd0);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 2'd0);
        wait_outst("drn_first", 5'd1, 10);
        command_out_ready = 1'b0;
        drive(1'b1, 8'h42, 1'b0, 8'h00, 2'd0);
        step();
        drive(1'b1, 8'h43, 1'b0, 8'h00, 2'd0);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 2'd0);
        step();
        chk("drn_head", command_out_payload, pl(8'h42));
        chk("drn_cnt", status_count, 5'd2);
        enabled_in = 1'b0;
        step();
        command_out_ready = 1'b1;
        wait_outst("drn_issued", 5'd3, 10);
        chk("drn_empty", status_empty, 1'b1);
        chk("drn_not_done", drain_done, 1'b0);
        command_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'h41 + 8'(i), 2'd0);
            step();
            $display("drain resp %0h rv=%0b outst=%0d done=%0b", 8'h41 + 8'(i),
                     response_out_valid, outstanding_count, drain_done);
            chk("drn_rv", response_out_valid, 1'b1);
            chk("drn_rtag", response_out_tag, 8'h41 + 8'(i));
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 2'd0);
        chk("drn_done_late", drain_done, 1'b0);
        step();
        chk("drn_done", drain_done, 1'b1);

        // Asynchronous reset in the middle of a pending transfer
        enabled_in = 1'b1;
        step();
        drive(1'b1, 8'h44, 1'b0, 8'h00, 2'd0);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 2'd0);
        step();
        chk("ar_pre_ov", command_out_valid, 1'b1);
        command_out_ready = 1'b1;
        rst_in = 1'b1;
        #1;
        $display("async reset ov=%0b cnt=%0d empty=%0b", command_out_valid, status_count, status_empty);
        chk("ar_ov", command_out_valid, 1'b0);
        chk("ar_payload", command_out_payload, 128'd0);
        chk("ar_rv", response_out_valid, 1'b0);
        chk("ar_rtag", {response_out_tag, response_out_code}, 10'd0);
        chk("ar_outst", outstanding_count, 5'd0);
        chk("ar_drain_done", drain_done, 1'b0);
        chk("ar_err", error_sticky, 2'b00);
        chk("ar_status", {status_full, status_almost_full, status_empty, status_count}, {3'b001, 5'd0});
        drive(1'b1, 8'h55, 1'b1, 8'h44, 2'd0);
        step();
        step();
        rst_in = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 2'd0);
        step();
        chk("ar_push_ignored", status_empty, 1'b1);
        chk("ar_resp_ignored", error_sticky, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
